// File: rtl/led_matrix_frame_tx.sv
// Serialising transmitter for the LED matrix link: shifts a frame out MSB-first
// on a divided data clock, then pulses a latch strobe.
module led_matrix_frame_tx #(
    parameter int NLEDS      = 64,
    parameter int DIV        = 4,
    parameter int STROBE_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NLEDS-1:0] frame_data,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             sdata,
    output logic             sclk,
    output logic             sstrobe,
    output logic             busy,
    output logic             done
);

    localparam int PMAX = (DIV > STROBE_LEN) ? DIV : STROBE_LEN;
    localparam int PW   = $clog2(PMAX) + 1;
    localparam int IW   = (NLEDS > 1) ? $clog2(NLEDS) : 1;

    localparam logic [PW-1:0] DIV_TC  = PW'(DIV - 1);
    localparam logic [PW-1:0] STB_TC  = PW'(STROBE_LEN - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(NLEDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW    = 3'd1,
        ST_HIGH   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_STROBE = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    phase, phase_n;
    logic [IW-1:0]    idx, idx_n;
    logic [NLEDS-1:0] shreg, shreg_n, shreg_shl;
    logic             sdata_n, sclk_n, sstrobe_n, busy_n, done_n;

    assign shreg_shl   = shreg << 1;
    assign frame_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= '0;
            idx     <= '0;
            shreg   <= '0;
            sdata   <= 1'b0;
            sclk    <= 1'b0;
            sstrobe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            sdata   <= sdata_n;
            sclk    <= sclk_n;
            sstrobe <= sstrobe_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Output registers are loaded with the value belonging to the state being
    // entered, so every pin changes exactly on the state transition edge.
    always_comb begin
        state_n   = state;
        phase_n   = phase + PW'(1);
        idx_n     = idx;
        shreg_n   = shreg;
        sdata_n   = sdata;
        sclk_n    = 1'b0;
        sstrobe_n = 1'b0;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                phase_n = '0;
                if (frame_valid) begin
                    state_n = ST_LOW;
                    shreg_n = frame_data;
                    idx_n   = IDX_TOP;
                    sdata_n = frame_data[NLEDS-1];
                end
            end
            ST_LOW: begin
                if (phase == DIV_TC) begin
                    state_n = ST_HIGH;
                    phase_n = '0;
                    sclk_n  = 1'b1;
                end
            end
            ST_HIGH: begin
                sclk_n = 1'b1;
                if (phase == DIV_TC) begin
                    phase_n = '0;
                    sclk_n  = 1'b0;
                    if (idx != '0) begin
                        state_n = ST_LOW;
                        idx_n   = idx - IW'(1);
                        shreg_n = shreg_shl;
                        sdata_n = shreg_shl[NLEDS-1];
                    end else begin
                        state_n = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (phase == DIV_TC) begin
                    state_n   = ST_STROBE;
                    phase_n   = '0;
                    sstrobe_n = 1'b1;
                end
            end
            ST_STROBE: begin
                sstrobe_n = 1'b1;
                if (phase == STB_TC) begin
                    state_n   = ST_IDLE;
                    phase_n   = '0;
                    sstrobe_n = 1'b0;
                    done_n    = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                phase_n = '0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_led_matrix_frame_tx.sv
// Scoreboard bench: a default-timing instance and a DIV=1/STROBE_LEN=1 instance,
// each checked by a reference serial receiver.
module tb_led_matrix_frame_tx;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fv = '0;
    logic [63:0] fd [2];
    logic [1:0]  ready_w, sdata_w, sclk_w, sstrobe_w, busy_w, done_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_matrix_frame_tx #(.NLEDS(64), .DIV(4), .STROBE_LEN(4)) u_dut (
        .clk(clk), .reset(reset), .frame_data(fd[0]), .frame_valid(fv[0]),
        .frame_ready(ready_w[0]), .sdata(sdata_w[0]), .sclk(sclk_w[0]),
        .sstrobe(sstrobe_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    led_matrix_frame_tx #(.NLEDS(64), .DIV(1), .STROBE_LEN(1)) u_dut_fast (
        .clk(clk), .reset(reset), .frame_data(fd[1]), .frame_valid(fv[1]),
        .frame_ready(ready_w[1]), .sdata(sdata_w[1]), .sclk(sclk_w[1]),
        .sstrobe(sstrobe_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int stb_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    int          cyc = 0;
    logic [63:0] rx [2];
    int          rises [2];
    int          st_start [2];
    int          st_len [2];
    int          done_cnt [2];
    int          since_chg [2];
    int          since_rise [2];
    bit          ignore [2];
    logic [1:0]  p_sclk = '0, p_sdata = '0, p_strobe = '0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rx[i] = '0; rises[i] = 0; st_start[i] = 0; st_len[i] = 0;
            done_cnt[i] = 0; since_chg[i] = 1000; since_rise[i] = 1000; ignore[i] = 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reference receiver, timing rules and scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            since_chg[i]++;
            since_rise[i]++;
            if (reset) begin
                rises[i] = 0;
                rx[i] = '0;
                ignore[i] = 1;
                if (i == 0) q0.delete(); else q1.delete();
            end else begin
                if (sclk_w[i] && !p_sclk[i]) begin
                    rises[i]++;
                    rx[i] = {rx[i][N-2:0], sdata_w[i]};
                    chk("setup_before_rise", 64'(since_chg[i] >= div_of(i)), 64'd1);
                    since_rise[i] = 0;
                end
                if (sdata_w[i] !== p_sdata[i]) begin
                    if (!ignore[i])
                        chk("hold_after_rise", 64'(since_rise[i] >= div_of(i)), 64'd1);
                    since_chg[i] = 0;
                end
                ignore[i] = 0;
                if (sstrobe_w[i])
                    chk("strobe_sclk_exclusive", 64'(sclk_w[i]), 64'd0);
                if (sstrobe_w[i] && !p_strobe[i]) begin
                    st_start[i] = cyc;
                    chk("strobe_has_frame", 64'(qsize(i) > 0), 64'd1);
                end
                if (!sstrobe_w[i] && p_strobe[i])
                    st_len[i] = cyc - st_start[i];
                if (done_w[i]) begin
                    if (qsize(i) == 0) begin
                        chk("done_has_frame", 64'd0, 64'd1);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("rx_value", rx[i], e.data);
                        chk("sclk_rises", 64'(rises[i]), 64'(N));
                        chk("strobe_len", 64'(st_len[i]), 64'(stb_of(i)));
                        chk("strobe_cycle", 64'(st_start[i]), 64'(e.acc + (2*N+1)*div_of(i)));
                        chk("done_cycle", 64'(cyc), 64'(e.acc + (2*N+1)*div_of(i) + stb_of(i)));
                    end
                    done_cnt[i]++;
                    rises[i] = 0;
                end
                if (fv[i] && ready_w[i]) begin
                    e.data = fd[i];
                    e.acc  = cyc + 1;
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
            p_sclk[i]   = sclk_w[i];
            p_sdata[i]  = sdata_w[i];
            p_strobe[i] = sstrobe_w[i];
        end
    end

    task automatic send(input int i, input logic [63:0] d);
        bit ok;
        ok = 0;
        fv[i] = 1'b1;
        fd[i] = d;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (ready_w[i]) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        fv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target);
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (done_cnt[i] >= target) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", 64'(done_cnt[i]), 64'(target));
    endtask

    task automatic wait_rises(input int n);
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (rises[0] >= n) begin ok = 1; break; end
        end
        if (!ok) chk("rise_timeout", 64'(rises[0]), 64'(n));
    endtask

    initial begin
        logic [63:0] x;
        int bad;
        bit ok;
        fd[0] = '0;
        fd[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdata", 64'(sdata_w[0]), 64'd0);
        chk("rst_sclk", 64'(sclk_w[0]), 64'd0);
        chk("rst_sstrobe", 64'(sstrobe_w[0]), 64'd0);
        chk("rst_busy", 64'(busy_w[0]), 64'd0);
        chk("rst_done", 64'(done_w[0]), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 64'(ready_w[0]), 64'd1);

        send(0, 64'hA5A5_0F0F_FFFF_0001);
        wait_done(0, 1);

        // Back-to-back: second frame must be taken in the done cycle.
        fv[0] = 1'b1;
        fd[0] = 64'h0;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_w[0]) begin ok = 1; break; end
        end
        chk("b2b_first_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        fd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (ready_w[0]) begin ok = 1; break; end
        end
        chk("b2b_second_accept", 64'(ok), 64'd1);
        chk("b2b_in_done_cycle", 64'(done_w[0]), 64'd1);
        @(posedge clk); #1;
        fv[0] = 1'b0;
        wait_done(0, 3);

        // Valid pulsed mid-frame with different data must be ignored.
        x = {$urandom, $urandom};
        send(0, x);
        wait_rises(30);
        fd[0] = ~x;
        fv[0] = 1'b1;
        chk("ready_low_midframe", 64'(ready_w[0]), 64'd0);
        @(posedge clk); #1;
        fv[0] = 1'b0;
        bad = 0;
        for (int t = 0; t < 3000; t++) begin
            if (done_w[0]) break;
            if (ready_w[0]) bad++;
            @(posedge clk); #1;
        end
        chk("ready_held_low", 64'(bad), 64'd0);
        wait_done(0, 4);

        // Reset in the middle of a frame drops it without a strobe.
        send(0, {$urandom, $urandom});
        wait_rises(20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_sdata", 64'(sdata_w[0]), 64'd0);
        chk("midrst_sclk", 64'(sclk_w[0]), 64'd0);
        chk("midrst_sstrobe", 64'(sstrobe_w[0]), 64'd0);
        chk("midrst_busy", 64'(busy_w[0]), 64'd0);
        chk("midrst_done", 64'(done_w[0]), 64'd0);
        chk("midrst_ready", 64'(ready_w[0]), 64'd1);
        send(0, 64'h1);
        wait_done(0, 5);
        chk("midrst_frame_count", 64'(done_cnt[0]), 64'd5);

        send(1, 64'h8000_0000_0000_0001);
        wait_done(1, 1);
        for (int k = 0; k < 3; k++) begin
            send(1, {$urandom, $urandom});
            wait_done(1, 2 + k);
        end
        for (int k = 0; k < 2; k++) begin
            send(0, {$urandom, $urandom});
            wait_done(0, 6 + k);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue0_empty", 64'(q0.size()), 64'd0);
        chk("queue1_empty", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
